// File: rtl/arb_pkg.sv
// Shared types and constants for the core memory arbiter.
// Holds the FSM state, grant encoding and access-size codes.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2,
        DONE = 2'd3
    } arb_state_e;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } arb_grant_e;

    localparam logic [2:0] SZ_B = 3'd1;
    localparam logic [2:0] SZ_H = 3'd2;
    localparam logic [2:0] SZ_W = 3'd4;

endpackage

// File: rtl/arb_lane_fmt.sv
// Combinational lane formatter: byte enables, write-lane replication and
// misalignment detection for a data-port access.
module arb_lane_fmt
    import arb_pkg::*;
(
    input  logic [2:0]  dlen,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misalign
);

    always_comb begin
        be        = 4'h0;
        wdata_rep = wdata;
        misalign  = 1'b0;
        case (dlen)
            SZ_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                misalign  = addr_lo[0];
            end
            SZ_W: begin
                be        = 4'hF;
                misalign  = |addr_lo;
            end
            // Any other size code is illegal and is reported as an error.
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Arbitrates the core's fetch and data ports onto one registered external
// bus with wait states, timeout, misalignment errors and a core stall.
module core_mem_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int DPRIO   = 1
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        IREQ,
    input  logic [31:0] IADDR,
    output logic        IACK,
    output logic [31:0] IDATA,
    input  logic        DAS,
    input  logic        DRD,
    input  logic        DWR,
    input  logic [31:0] DADDR,
    input  logic [2:0]  DLEN,
    input  logic [31:0] DATAO,
    output logic [31:0] DATAI,
    output logic        DACK,
    output logic        HLT,
    output logic        BERR,
    output logic [31:0] XADDR,
    output logic [31:0] XDATAO,
    output logic [3:0]  XBE,
    output logic        XRD,
    output logic        XWR,
    input  logic [31:0] XDATAI,
    input  logic        XRDY,
    input  logic        XBERR,
    output arb_state_e  dbg_state
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    arb_state_e  state_q, state_d;
    arb_grant_e  last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] xaddr_q, xaddr_d;
    logic [31:0] xdatao_q, xdatao_d;
    logic [3:0]  xbe_q, xbe_d;
    logic        xrd_q, xrd_d;
    logic        xwr_q, xwr_d;
    logic        iack_q, iack_d;
    logic        dack_q, dack_d;
    logic        berr_q, berr_d;
    logic [31:0] idata_q, idata_d;
    logic [31:0] datai_q, datai_d;

    logic        d_req;
    logic        fmt_misalign;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic        tmo_hit;
    arb_grant_e  pick;

    assign d_req = DAS & (DRD | DWR);

    arb_lane_fmt u_lane_fmt (
        .dlen      (DLEN),
        .addr_lo   (DADDR[1:0]),
        .wdata     (DATAO),
        .be        (fmt_be),
        .wdata_rep (fmt_wdata),
        .misalign  (fmt_misalign)
    );

    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TMO_LAST) && !XRDY;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        xaddr_d  = xaddr_q;
        xdatao_d = xdatao_q;
        xbe_d    = xbe_q;
        xrd_d    = xrd_q;
        xwr_d    = xwr_q;
        iack_d   = 1'b0;
        dack_d   = 1'b0;
        berr_d   = 1'b0;
        idata_d  = idata_q;
        datai_d  = datai_q;
        // Data wins when alone, under fixed priority, or when fetch went last.
        pick     = (d_req && (!IREQ || DPRIO != 0 || last_q == FETCH)) ? DATA : FETCH;

        case (state_q)
            IDLE: begin
                if (IREQ || d_req) begin
                    last_d = pick;
                    cnt_d  = '0;
                    if (pick == FETCH) begin
                        if (IADDR[1:0] != 2'b00) begin
                            state_d = DONE;
                            iack_d  = 1'b1;
                            berr_d  = 1'b1;
                        end else begin
                            state_d = IBUS;
                            xaddr_d = {IADDR[31:2], 2'b00};
                            xbe_d   = 4'hF;
                            xrd_d   = 1'b1;
                        end
                    end else begin
                        if (fmt_misalign) begin
                            state_d = DONE;
                            dack_d  = 1'b1;
                            berr_d  = 1'b1;
                        end else begin
                            state_d  = DBUS;
                            xaddr_d  = {DADDR[31:2], 2'b00};
                            xbe_d    = fmt_be;
                            xdatao_d = fmt_wdata;
                            xrd_d    = DRD;
                            xwr_d    = DWR & ~DRD;
                        end
                    end
                end
            end
            IBUS, DBUS: begin
                if (XRDY || XBERR || tmo_hit) begin
                    state_d = DONE;
                    xrd_d   = 1'b0;
                    xwr_d   = 1'b0;
                    berr_d  = XBERR | tmo_hit;
                    iack_d  = (state_q == IBUS);
                    dack_d  = (state_q == DBUS);
                    // Timeout carries no valid data, so nothing is latched then.
                    if (XRDY || XBERR) begin
                        if (state_q == IBUS) begin
                            idata_d = XDATAI;
                        end else if (xrd_q) begin
                            datai_d = XDATAI;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q  <= IDLE;
            last_q   <= FETCH;
            cnt_q    <= '0;
            xaddr_q  <= '0;
            xdatao_q <= '0;
            xbe_q    <= '0;
            xrd_q    <= 1'b0;
            xwr_q    <= 1'b0;
            iack_q   <= 1'b0;
            dack_q   <= 1'b0;
            berr_q   <= 1'b0;
            idata_q  <= '0;
            datai_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            xaddr_q  <= xaddr_d;
            xdatao_q <= xdatao_d;
            xbe_q    <= xbe_d;
            xrd_q    <= xrd_d;
            xwr_q    <= xwr_d;
            iack_q   <= iack_d;
            dack_q   <= dack_d;
            berr_q   <= berr_d;
            idata_q  <= idata_d;
            datai_q  <= datai_d;
        end
    end

    assign IACK      = iack_q;
    assign DACK      = dack_q;
    assign BERR      = berr_q;
    assign IDATA     = idata_q;
    assign DATAI     = datai_q;
    assign XADDR     = xaddr_q;
    assign XDATAO    = xdatao_q;
    assign XBE       = xbe_q;
    assign XRD       = xrd_q;
    assign XWR       = xwr_q;
    assign HLT       = (IREQ & ~iack_q) | (d_req & ~dack_q);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: a round-robin/timeout-4 instance is
// scoreboarded on every ACK; a fixed-priority twin checks data-first grants.
module tb_core_mem_arbiter;
    import arb_pkg::*;

    logic        CLK = 1'b0;
    logic        RES;
    logic        IREQ;
    logic [31:0] IADDR;
    logic        DAS, DRD, DWR;
    logic [31:0] DADDR;
    logic [2:0]  DLEN;
    logic [31:0] DATAO;
    logic [31:0] XDATAI;
    logic        XRDY, XBERR;

    logic        IACK, DACK, HLT, BERR, XRD, XWR;
    logic [31:0] IDATA, DATAI, XADDR, XDATAO;
    logic [3:0]  XBE;
    arb_state_e  dbg_state;

    logic        iack_1, dack_1, hlt_1, berr_1, xrd_1, xwr_1;
    logic [31:0] idata_1, datai_1, xaddr_1, xdatao_1;
    logic [3:0]  xbe_1;
    arb_state_e  dbg_state_1;

    // Entry: [34:33] expected {IACK,DACK}, [32] BERR, [31:0] IDATA or DATAI.
    logic [34:0] exp_q[$];
    logic [31:0] last_datai;
    logic [31:0] last_idata;
    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    core_mem_arbiter #(.TIMEOUT(4), .DPRIO(0)) u_dut (
        .CLK(CLK), .RES(RES), .IREQ(IREQ), .IADDR(IADDR), .IACK(IACK), .IDATA(IDATA),
        .DAS(DAS), .DRD(DRD), .DWR(DWR), .DADDR(DADDR), .DLEN(DLEN), .DATAO(DATAO),
        .DATAI(DATAI), .DACK(DACK), .HLT(HLT), .BERR(BERR), .XADDR(XADDR),
        .XDATAO(XDATAO), .XBE(XBE), .XRD(XRD), .XWR(XWR), .XDATAI(XDATAI),
        .XRDY(XRDY), .XBERR(XBERR), .dbg_state(dbg_state)
    );

    core_mem_arbiter #(.TIMEOUT(255), .DPRIO(1)) u_dut_prio (
        .CLK(CLK), .RES(RES), .IREQ(IREQ), .IADDR(IADDR), .IACK(iack_1), .IDATA(idata_1),
        .DAS(DAS), .DRD(DRD), .DWR(DWR), .DADDR(DADDR), .DLEN(DLEN), .DATAO(DATAO),
        .DATAI(datai_1), .DACK(dack_1), .HLT(hlt_1), .BERR(berr_1), .XADDR(xaddr_1),
        .XDATAO(xdatao_1), .XBE(xbe_1), .XRD(xrd_1), .XWR(xwr_1), .XDATAI(XDATAI),
        .XRDY(XRDY), .XBERR(XBERR), .dbg_state(dbg_state_1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ack(input int max_cycles);
        int n = 0;
        while (!(IACK || DACK) && n < max_cycles) begin
            tick();
            n++;
        end
        if (!(IACK || DACK)) begin
            total++;
            bad++;
            $error("FAIL ack_timeout: observed=no ack expected=ack within %0d cycles", max_cycles);
        end
    endtask

    // Scoreboard: every ACK pulse of the main instance pops one expectation.
    always @(negedge CLK) begin
        logic [34:0] e;
        if (RES && (IACK || DACK)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL ack_unexpected: observed={IACK,DACK}=%b%b expected=none", IACK, DACK);
            end else begin
                e = exp_q.pop_front();
                check("ack_port", {30'd0, IACK, DACK}, {30'd0, e[34:33]});
                check("ack_berr", {31'd0, BERR}, {31'd0, e[32]});
                check("ack_data", IACK ? IDATA : DATAI, e[31:0]);
            end
        end
    end

    initial begin
        #500000;
        $error("FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] t_addr[5];
        logic [2:0]  t_len[5];
        logic [3:0]  t_be[5];
        logic        t_err[5];
        logic        t_xberr[5];
        logic [31:0] rd;

        RES = 1'b0; IREQ = 1'b0; IADDR = '0; DAS = 1'b0; DRD = 1'b0; DWR = 1'b0;
        DADDR = '0; DLEN = '0; DATAO = '0; XDATAI = '0; XRDY = 1'b0; XBERR = 1'b0;
        last_datai = '0;
        last_idata = '0;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_strobes", {24'd0, XRD, XWR, XBE, IACK, DACK}, 32'd0);
        check("rst_berr_hlt", {30'd0, BERR, HLT}, 32'd0);
        check("rst_xaddr", XADDR, 32'd0);
        check("rst_xdatao", XDATAO, 32'd0);
        check("rst_rdata", IDATA | DATAI, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        RES = 1'b1;

        // Both ports held: round-robin alternates D,F,D,F; fixed priority stays on data.
        IREQ = 1'b1; IADDR = 32'h400;
        DAS = 1'b1; DRD = 1'b1; DWR = 1'b0; DADDR = 32'h300; DLEN = SZ_W;
        XRDY = 1'b1; XDATAI = 32'h55;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back((k % 2 == 0) ? {2'b01, 1'b0, 32'h55} : {2'b10, 1'b0, 32'h55});
        end
        last_datai = 32'h55;
        last_idata = 32'h55;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_xaddr", XADDR, (k % 2 == 0) ? 32'h300 : 32'h400);
            check("prio_xaddr", xaddr_1, 32'h300);
            tick();
            check("prio_dack", {30'd0, iack_1, dack_1}, 32'd1);
            if (k == 3) begin
                IREQ = 1'b0; DAS = 1'b0; DRD = 1'b0;
            end else begin
                tick();
            end
        end
        tick();

        // Zero-wait fetch.
        IREQ = 1'b1; IADDR = 32'h100; XDATAI = 32'h13; XRDY = 1'b1;
        exp_q.push_back({2'b10, 1'b0, 32'h13});
        last_idata = 32'h13;
        #1;
        check("f_hlt_c0", {31'd0, HLT}, 32'd1);
        tick();
        check("f_xaddr", XADDR, 32'h100);
        check("f_xbe_xrd", {27'd0, XBE, XRD}, {27'd0, 4'hF, 1'b1});
        check("f_hlt_c1", {31'd0, HLT}, 32'd1);
        tick();
        check("f_iack_c2", {31'd0, IACK}, 32'd1);
        check("f_hlt_c2", {31'd0, HLT}, 32'd0);
        IREQ = 1'b0;
        tick();

        // Byte store with three wait states.
        DAS = 1'b1; DWR = 1'b1; DRD = 1'b0; DADDR = 32'h203; DLEN = SZ_B; DATAO = 32'hA5;
        XRDY = 1'b0;
        exp_q.push_back({2'b01, 1'b0, last_datai});
        tick();
        check("bs_xwr", {30'd0, XWR, XRD}, 32'd2);
        check("bs_xbe", {28'd0, XBE}, 32'h8);
        check("bs_xdatao", XDATAO, 32'hA5A5A5A5);
        check("bs_xaddr", XADDR, 32'h200);
        tick();
        tick();
        check("bs_wait_xwr", {30'd0, XWR, HLT}, 32'd3);
        tick();
        XRDY = 1'b1;
        tick();
        check("bs_dack_c5", {30'd0, DACK, XWR}, 32'd2);
        DAS = 1'b0; DWR = 1'b0;
        tick();

        // Misaligned word load completes with an error and no bus cycle.
        DAS = 1'b1; DRD = 1'b1; DADDR = 32'h202; DLEN = SZ_W;
        exp_q.push_back({2'b01, 1'b1, last_datai});
        tick();
        check("mis_c1", {29'd0, DACK, BERR, XRD}, 32'd6);
        DAS = 1'b0; DRD = 1'b0;
        tick();

        // Lane/alignment table of data reads.
        t_addr  = '{32'h201, 32'h702, 32'h701, 32'h204, 32'h208};
        t_len   = '{SZ_B, SZ_H, SZ_H, 3'd3, SZ_W};
        t_be    = '{4'b0010, 4'b1100, 4'h0, 4'h0, 4'hF};
        t_err   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        t_xberr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            rd = $urandom();
            DAS = 1'b1; DRD = 1'b1; DADDR = t_addr[i]; DLEN = t_len[i];
            XDATAI = rd; XRDY = 1'b1; XBERR = t_xberr[i];
            if (!t_err[i]) last_datai = rd;
            exp_q.push_back({2'b01, t_err[i] | t_xberr[i], last_datai});
            tick();
            if (!t_err[i]) begin
                check("tbl_xbe", {28'd0, XBE}, {28'd0, t_be[i]});
                check("tbl_xaddr", XADDR, {t_addr[i][31:2], 2'b00});
            end
            wait_ack(6);
            DAS = 1'b0; DRD = 1'b0; XBERR = 1'b0;
            tick();
        end

        // Misaligned fetch.
        IREQ = 1'b1; IADDR = 32'h102;
        exp_q.push_back({2'b10, 1'b1, last_idata});
        tick();
        check("mis_fetch_xrd", {31'd0, XRD}, 32'd0);
        wait_ack(4);
        IREQ = 1'b0;
        tick();

        // Timeout of four wait cycles, then a normal fetch.
        DAS = 1'b1; DRD = 1'b1; DADDR = 32'h500; DLEN = SZ_W; XRDY = 1'b0; XDATAI = 32'hDEAD;
        exp_q.push_back({2'b01, 1'b1, last_datai});
        for (int i = 0; i < 4; i++) begin
            tick();
            check("tmo_xrd", {31'd0, XRD}, 32'd1);
        end
        tick();
        check("tmo_dack", {29'd0, DACK, BERR, XRD}, 32'd6);
        DAS = 1'b0; DRD = 1'b0;
        IREQ = 1'b1; IADDR = 32'h600; XRDY = 1'b1; XDATAI = 32'h77;
        exp_q.push_back({2'b10, 1'b0, 32'h77});
        tick();
        wait_ack(6);
        IREQ = 1'b0;
        tick();

        // Reset during a half-word store; the pending fetch runs afterwards.
        DAS = 1'b1; DWR = 1'b1; DRD = 1'b0; DADDR = 32'h700; DLEN = SZ_H; DATAO = 32'hBEEF1234;
        IREQ = 1'b1; IADDR = 32'h800; XDATAI = 32'h99; XRDY = 1'b0;
        tick();
        check("rs_xwr", {30'd0, XWR, XRD}, 32'd2);
        check("rs_xbe", {28'd0, XBE}, 32'h3);
        check("rs_xdatao", XDATAO, 32'h12341234);
        tick();
        RES = 1'b0;
        #1;
        check("rs_abort", {30'd0, XWR, DACK}, 32'd0);
        check("rs_state", 32'(dbg_state), 32'(IDLE));
        DAS = 1'b0; DWR = 1'b0;
        tick();
        RES = 1'b1; XRDY = 1'b1;
        exp_q.push_back({2'b10, 1'b0, 32'h99});
        wait_ack(6);
        IREQ = 1'b0;
        tick();
        tick();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
Shares one external memory bus between the core's instruction-fetch port and its data port. Grants one requester at a time and runs a registered bus cycle with wait-state support. Generates the core's HLT stall and BERR. Handles byte-enable generation, write-lane replication, misalignment detection and bus timeout. Sits between the pipeline core and the SoC memory/IO fabric.

Parameters:
TIMEOUT, 255, wait cycles tolerated before aborting a bus cycle with an error; 0 disables the timeout.
DPRIO, 1, 1 = data port wins simultaneous requests; 0 = round-robin.

Ports:
CLK  in  1  clock, rising edge
RES  in  1  reset, asynchronous, active-low
IREQ  in  1  fetch request, level; held until IACK
IADDR  in  32  fetch address; stable while IREQ is high
IACK  out  1  one-cycle fetch completion pulse
IDATA  out  32  fetched word; valid when IACK is high, held until the next IACK
DAS  in  1  data request; counts only when DRD or DWR is high; held until DACK
DRD  in  1  data read
DWR  in  1  data write
DADDR  in  32  data byte address
DLEN  in  3  access size: 1, 2 or 4 bytes
DATAO  in  32  write data, right-aligned
DATAI  out  32  raw read word; valid when DACK is high
DACK  out  1  one-cycle data completion pulse
HLT  out  1  core stall
BERR  out  1  one-cycle error pulse, coincident with IACK or DACK
XADDR  out  32  bus address, word-aligned ([1:0]=0)
XDATAO  out  32  bus write data
XBE  out  4  byte enables
XRD  out  1  bus read strobe
XWR  out  1  bus write strobe
XDATAI  in  32  bus read data
XRDY  in  1  bus cycle complete
XBERR  in  1  bus error; sampled with XRDY, or alone

Behaviour:
- Reset (RES=0, asynchronous): state IDLE. All outputs are 0. Timeout counter is 0. Last-grant register = FETCH.
- States: IDLE, IBUS, DBUS, DONE. All bus outputs are registered.
- IDLE, no pending request: stay in IDLE.
- IDLE, only a fetch request: go to IBUS. XADDR={IADDR[31:2],2'b00}, XBE=4'hF, XRD=1.
- IDLE, only a data request: go to DBUS. Latch address, XBE and write data. XRD=DRD, XWR=DWR&~DRD (read wins if both are set).
- IDLE, both requesting: DPRIO=1 → data wins. DPRIO=0 → grant the port opposite the last grant. Update the last-grant register on every grant.
- Misalignment (checked in IDLE; no bus cycle issued, go straight to DONE with BERR=1):
  - IADDR[1:0]≠0
  - DLEN∉{1,2,4}
  - DLEN=2 with DADDR[0]=1
  - DLEN=4 with DADDR[1:0]≠0
- Byte enables:
  - DLEN=1: XBE=4'b0001<<DADDR[1:0]
  - DLEN=2: XBE=4'b0011<<{DADDR[1],1'b0}
  - DLEN=4: XBE=4'hF
- Write lane replication:
  - byte: XDATAO={4{DATAO[7:0]}}
  - half: XDATAO={2{DATAO[15:0]}}
  - word: XDATAO=DATAO
- IBUS/DBUS, XRDY=1 or XBERR=1:
  - Drop XRD/XWR and go to DONE.
  - Latch XDATAI into IDATA or DATAI (read only; write leaves DATAI unchanged).
  - BERR=XBERR.
- IBUS/DBUS, wait cycles: the counter increments each cycle with XRDY=0. If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with XRDY still 0: drop the strobes and go to DONE with BERR=1. Counter clears on entry to IBUS/DBUS.
- DONE (one cycle):
  - Pulse IACK or DACK for the granted port, with BERR if it was set.
  - Requests are ignored this cycle, so a request still held on its ACK cycle is not reissued.
  - Return to IDLE.
- Latency: zero-wait read takes 2 cycles from request to ACK. Each bus wait state adds 1 cycle. Back-to-back transactions occur every 3 cycles minimum.
- HLT (combinational) = (IREQ&~IACK) | (DAS&(DRD|DWR)&~DACK).
- Reset asserted mid-cycle: strobes drop immediately. No ACK is issued for the aborted transaction.
- XBERR and XRDY asserted together: treated as an error; data is still latched.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE,IBUS,DBUS,DONE}
  - grant enum {FETCH,DATA}
  - size constants SZ_B=1, SZ_H=2, SZ_W=4
- Sub-module arb_lane_fmt: combinational XBE, XDATAO and misalignment-flag generation from DLEN, DADDR[1:0] and DATAO.
- The FSM, timeout counter and grant register stay in the top module.

Test Plan:
1. Fetch, zero-wait: IREQ with IADDR=0x100, bus returns XRDY on the first XRD cycle with XDATAI=0x00000013 → XADDR=0x100, XBE=F; IACK at cycle 2, IDATA=0x13, HLT high cycles 0–1.
2. Byte store: DAS/DWR, DADDR=0x203, DLEN=1, DATAO=0xA5, XRDY after 3 waits → XBE=4'b1000, XDATAO=0xA5A5A5A5; DACK 5 cycles after request.
3. Simultaneous requests, DPRIO=0: fetch and data held continuously → grants alternate starting with DATA (last-grant reset = FETCH); DPRIO=1 → DATA granted first.
4. Misaligned word load: DADDR=0x202, DLEN=4 → no XRD; DACK and BERR at cycle 1.
5. Timeout, TIMEOUT=4, XRDY held at 0 → XRD high 4 cycles, then DACK+BERR; next request proceeds normally.
6. Reset during DBUS with XWR=1 → XWR=0 immediately, no DACK; after release, a pending IREQ is serviced normally.
